// File: rtl/ikaopll_dac_seq_pkg.sv
// Shared definitions for the OPLL DAC sequencer: FSM encoding, frame length
// and the slot each melody/rhythm channel occupies within a sample frame.
package ikaopll_dac_seq_pkg;

  localparam int FRAME_LEN_DEF = 18;
  localparam int N_MEL         = 9;
  localparam int N_RHY         = 5;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } dac_state_e;

  // Melody channels CH1..CH9
  function automatic logic [4:0] mel_slot(input int ch);
    case (ch)
      0:       return 5'd5;
      1:       return 5'd8;
      2:       return 5'd9;
      3:       return 5'd13;
      4:       return 5'd16;
      5:       return 5'd17;
      6:       return 5'd3;
      7:       return 5'd0;
      8:       return 5'd1;
      default: return 5'd31;
    endcase
  endfunction

  // Rhythm voices BD, HH, SD, TOM, CYM
  function automatic logic [4:0] rhy_slot(input int ch);
    case (ch)
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd2;
      3:       return 5'd3;
      4:       return 5'd4;
      default: return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/ikaopll_dac_seq_slotdec.sv
// Combinational decode of (slot, rhythm mode, mute mask) into the melody and
// rhythm output strobes.
module ikaopll_dac_seq_slotdec
  import ikaopll_dac_seq_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic [4:0]  i_slot,
  input  logic        i_rhythm,
  input  logic [13:0] i_mute,
  output logic        o_mo,
  output logic        o_ro
);

  logic [N_MEL-1:0] mel_hit;
  logic [N_RHY-1:0] rhy_hit;

  generate
    for (genvar gi = 0; gi < N_MEL; gi++) begin : g_mel
      localparam logic [4:0] SLOT     = mel_slot(gi);
      localparam bit         IN_FRAME = (int'(SLOT) < FRAME_LEN);
      // CH7..CH9 give their slots to the percussion voices in rhythm mode
      localparam bit         SHARED   = (gi >= 6);
      assign mel_hit[gi] = IN_FRAME && (i_slot == SLOT) && !i_mute[gi] &&
                           !(SHARED && i_rhythm);
    end

    for (genvar gi = 0; gi < N_RHY; gi++) begin : g_rhy
      localparam logic [4:0] SLOT     = rhy_slot(gi);
      localparam bit         IN_FRAME = (int'(SLOT) < FRAME_LEN);
      assign rhy_hit[gi] = IN_FRAME && i_rhythm && (i_slot == SLOT) &&
                           !i_mute[N_MEL+gi];
    end
  endgenerate

  assign o_mo = |mel_hit;
  assign o_ro = |rhy_hit;

endmodule

// File: rtl/ikaopll_dac_seq.sv
// DAC timing sequencer: locks onto the frame-start marker, walks the slot
// counter and emits registered melody/rhythm DAC strobes per slot.
module ikaopll_dac_seq
  import ikaopll_dac_seq_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST_n,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_CYCLE_00,
  input  logic        i_RHYTHM_EN,
  input  logic [13:0] i_MUTE,
  output logic        o_MO_CTRL,
  output logic        o_RO_CTRL,
  output logic        o_DAC_EN,
  output logic        o_INHIBIT_FDBK,
  output logic        o_CYCLE_00,
  output logic [4:0]  o_SLOT,
  output logic        o_RHYTHM_EN_EFF,
  output logic        o_SYNC_LOST
);

  localparam logic [4:0] LAST_SLOT = 5'(FRAME_LEN - 1);

  dac_state_e  state_q, state_d;
  logic [4:0]  slot_q, slot_d;
  logic        good_q, good_d;
  logic        sync_lost_q, sync_lost_d;
  logic        rhythm_q, rhythm_d;
  logic [13:0] mute_q, mute_d;
  logic        mo_q, mo_d;
  logic        ro_q, ro_d;
  logic        dac_en_q, dac_en_d;
  logic        inhibit_q, inhibit_d;
  logic        cyc00_q, cyc00_d;

  logic        en;
  logic        at_last;
  logic        dec_mo, dec_ro;

  assign en      = !i_phi1_NCEN_n;
  assign at_last = (slot_q == LAST_SLOT);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    good_d      = good_q;
    sync_lost_d = sync_lost_q;
    rhythm_d    = rhythm_q;
    mute_d      = mute_q;
    if (en) begin
      case (state_q)
        ST_UNSYNC: begin
          slot_d = '0;
          if (i_CYCLE_00) state_d = ST_RUN;
        end
        default: begin
          // Mode and mute only change on a frame boundary
          if (at_last) begin
            rhythm_d = i_RHYTHM_EN;
            mute_d   = i_MUTE;
          end
          slot_d = (at_last || i_CYCLE_00) ? 5'd0 : slot_q + 5'd1;
          if (at_last && i_CYCLE_00) begin
            if (state_q == ST_RESYNC) begin
              // good_q remembers one good boundary already seen
              if (good_q) begin
                state_d = ST_RUN;
                good_d  = 1'b0;
              end else begin
                good_d  = 1'b1;
              end
            end
          end else if (at_last || i_CYCLE_00) begin
            sync_lost_d = 1'b1;
            state_d     = ST_RESYNC;
            good_d      = 1'b0;
          end
        end
      endcase
    end
  end

  // Decode against the upcoming slot so strobes move together with o_SLOT
  ikaopll_dac_seq_slotdec #(
    .FRAME_LEN (FRAME_LEN)
  ) u_slotdec (
    .i_slot   (slot_d),
    .i_rhythm (rhythm_d),
    .i_mute   (mute_d),
    .o_mo     (dec_mo),
    .o_ro     (dec_ro)
  );

  always_comb begin
    mo_d      = mo_q;
    ro_d      = ro_q;
    inhibit_d = inhibit_q;
    dac_en_d  = dac_en_q;
    cyc00_d   = cyc00_q;
    if (en) begin
      mo_d      = (state_d != ST_UNSYNC) && dec_mo;
      ro_d      = (state_d != ST_UNSYNC) && dec_ro;
      inhibit_d = !(mo_d || ro_d);
      dac_en_d  = (mo_q || ro_q) && (state_d == ST_RUN);
      cyc00_d   = (state_d != ST_UNSYNC) && (slot_d == 5'd0);
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      state_q     <= ST_UNSYNC;
      slot_q      <= '0;
      good_q      <= 1'b0;
      sync_lost_q <= 1'b0;
      rhythm_q    <= 1'b0;
      mute_q      <= '0;
      mo_q        <= 1'b0;
      ro_q        <= 1'b0;
      dac_en_q    <= 1'b0;
      inhibit_q   <= 1'b1;
      cyc00_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      good_q      <= good_d;
      sync_lost_q <= sync_lost_d;
      rhythm_q    <= rhythm_d;
      mute_q      <= mute_d;
      mo_q        <= mo_d;
      ro_q        <= ro_d;
      dac_en_q    <= dac_en_d;
      inhibit_q   <= inhibit_d;
      cyc00_q     <= cyc00_d;
    end
  end

  assign o_MO_CTRL       = mo_q;
  assign o_RO_CTRL       = ro_q;
  assign o_DAC_EN        = dac_en_q;
  assign o_INHIBIT_FDBK  = inhibit_q;
  assign o_CYCLE_00      = cyc00_q;
  assign o_SLOT          = slot_q;
  assign o_RHYTHM_EN_EFF = rhythm_q;
  assign o_SYNC_LOST     = sync_lost_q;

endmodule

// File: tb/tb_ikaopll_dac_seq.sv
// Directed bench for the DAC sequencer: per-frame slot masks of every strobe
// are compared against hand-derived bit masks (bit n = slot n).
module tb_ikaopll_dac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ncen, cyc_in, rhy_in;
  logic [13:0] mute_in;
  logic        mo, ro, dac, inh, cyc_out, rhy_eff, sync_lost;
  logic [4:0]  slot;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] MEL9   = 32'h3232B; // slots 0,1,3,5,8,9,13,16,17
  localparam logic [31:0] MEL6   = 32'h32320; // slots 5,8,9,13,16,17
  localparam logic [31:0] RHY    = 32'h0001F; // slots 0..4
  localparam logic [31:0] MEL6_M = 32'h32300; // CH1 (slot 5) muted
  localparam logic [31:0] RHY_M  = 32'h0000F; // CYM (slot 4) muted
  localparam logic [31:0] FULL   = 32'h3FFFF;

  ikaopll_dac_seq dut (
    .i_EMUCLK        (clk),
    .i_RST_n         (rst_n),
    .i_phi1_NCEN_n   (ncen),
    .i_CYCLE_00      (cyc_in),
    .i_RHYTHM_EN     (rhy_in),
    .i_MUTE          (mute_in),
    .o_MO_CTRL       (mo),
    .o_RO_CTRL       (ro),
    .o_DAC_EN        (dac),
    .o_INHIBIT_FDBK  (inh),
    .o_CYCLE_00      (cyc_out),
    .o_SLOT          (slot),
    .o_RHYTHM_EN_EFF (rhy_eff),
    .o_SYNC_LOST     (sync_lost)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // DAC strobe is the MO|RO mask one slot later; c is slot 17 of the previous frame
  function automatic logic [31:0] rot18(input logic [31:0] m, input logic c);
    return ((m << 1) | 32'(c)) & FULL;
  endfunction

  // Runs one frame starting at slot 0. early>=0 pulses i_CYCLE_00 at that slot
  // and ends the frame there; chg_slot>=0 changes mode/mute at that slot.
  task automatic run_frame(input string tag, input int early, input bit pulse_end,
                           input int chg_slot, input logic chg_rhy, input logic [13:0] chg_mute,
                           input logic [31:0] e_mo, input logic [31:0] e_ro,
                           input logic [31:0] e_dac, input logic e_rhy, input logic e_sl);
    logic [31:0] mo_m, ro_m, dac_m, inh_m, c00_m, lenm;
    logic        rhy_s, sl_s;
    int          n, slot_err;
    mo_m = '0; ro_m = '0; dac_m = '0; inh_m = '0; c00_m = '0;
    rhy_s = 1'b0; sl_s = 1'b0; n = 18; slot_err = 0;
    for (int i = 0; i < 18; i++) begin
      if (int'(slot) != i) slot_err++;
      mo_m[i]  = mo;
      ro_m[i]  = ro;
      dac_m[i] = dac;
      inh_m[i] = inh;
      c00_m[i] = cyc_out;
      if (i == 10) begin
        rhy_s = rhy_eff;
        sl_s  = sync_lost;
      end
      if (i == chg_slot) begin
        rhy_in  = chg_rhy;
        mute_in = chg_mute;
      end
      cyc_in = (i == early) || (i == 17 && pulse_end);
      step;
      cyc_in = 1'b0;
      if (i == early) begin
        n = i + 1;
        break;
      end
    end
    lenm = (32'd1 << n) - 32'd1;
    check({tag, ".slot_seq"}, 32'(slot_err), 32'd0);
    check({tag, ".mo"},  mo_m,  e_mo & lenm);
    check({tag, ".ro"},  ro_m,  e_ro & lenm);
    check({tag, ".dac"}, dac_m, e_dac & lenm);
    check({tag, ".inh"}, inh_m, ~(e_mo | e_ro) & lenm);
    check({tag, ".c00"}, c00_m, 32'd1);
    check({tag, ".rhy_eff"},   32'(rhy_s), 32'(e_rhy));
    check({tag, ".sync_lost"}, 32'(sl_s),  32'(e_sl));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    rst_n = 1'b0; ncen = 1'b0; cyc_in = 1'b0; rhy_in = 1'b0; mute_in = '0;
    step;
    step;
    check("rst.slot", 32'(slot), 32'd0);
    check("rst.mo",   32'(mo),   32'd0);
    check("rst.ro",   32'(ro),   32'd0);
    check("rst.dac",  32'(dac),  32'd0);
    check("rst.c00",  32'(cyc_out), 32'd0);
    check("rst.inh",  32'(inh),  32'd1);
    check("rst.rhy",  32'(rhy_eff), 32'd0);
    check("rst.sl",   32'(sync_lost), 32'd0);

    rst_n = 1'b1;
    step; step; step;
    check("unsync.c00", 32'(cyc_out), 32'd0);
    check("unsync.inh", 32'(inh), 32'd1);

    cyc_in = 1'b1;
    step;
    cyc_in = 1'b0;
    check("lock.c00", 32'(cyc_out), 32'd1);

    run_frame("f1_melody", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, rot18(MEL9, 1'b0), 1'b0, 1'b0);
    run_frame("f2_melody", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, rot18(MEL9, 1'b1), 1'b0, 1'b0);
    run_frame("f3_rhy_req", -1, 1, 7, 1'b1, 14'h0, MEL9, 0, rot18(MEL9, 1'b1), 1'b0, 1'b0);
    run_frame("f4_rhythm", -1, 1, 7, 1'b1, 14'h2001, MEL6, RHY, rot18(MEL6 | RHY, 1'b1), 1'b1, 1'b0);
    run_frame("f5_muted", -1, 1, 3, 1'b0, 14'h0, MEL6_M, RHY_M, rot18(MEL6_M | RHY_M, 1'b1), 1'b1, 1'b0);
    run_frame("f6_no_pulse", -1, 0, -1, 1'b0, 14'h0, MEL9, 0, rot18(MEL9, 1'b1), 1'b0, 1'b0);
    check("miss.sync_lost", 32'(sync_lost), 32'd1);
    run_frame("f7_resync1", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, 0, 1'b0, 1'b1);
    run_frame("f8_resync2", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, 0, 1'b0, 1'b1);
    run_frame("f9_run", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, rot18(MEL9, 1'b1), 1'b0, 1'b1);

    // Reset mid-frame with the clock enable deasserted
    for (int k = 0; k < 40 && slot != 5'd12; k++) step;
    check("reach_slot12", 32'(slot), 32'd12);
    rhy_in = 1'b1; mute_in = 14'h3FFF;
    ncen = 1'b1; rst_n = 1'b0;
    step;
    check("mrst.slot", 32'(slot), 32'd0);
    check("mrst.mo",   32'(mo),   32'd0);
    check("mrst.ro",   32'(ro),   32'd0);
    check("mrst.dac",  32'(dac),  32'd0);
    check("mrst.c00",  32'(cyc_out), 32'd0);
    check("mrst.inh",  32'(inh),  32'd1);
    check("mrst.rhy",  32'(rhy_eff), 32'd0);
    check("mrst.sl",   32'(sync_lost), 32'd0);
    rst_n = 1'b1; ncen = 1'b0; rhy_in = 1'b0; mute_in = '0;
    act = 0;
    for (int k = 0; k < 25; k++) begin
      step;
      if (mo || ro || dac || cyc_out || !inh || slot != 5'd0) act++;
    end
    check("idle_quiet", 32'(act), 32'd0);

    // Frame marker while the enable is inactive must not start the sequencer
    ncen = 1'b1; cyc_in = 1'b1;
    step; step;
    check("gated.c00", 32'(cyc_out), 32'd0);
    ncen = 1'b0;
    step;
    cyc_in = 1'b0;
    check("start.c00", 32'(cyc_out), 32'd1);

    run_frame("f11_restart", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, rot18(MEL9, 1'b0), 1'b0, 1'b0);
    run_frame("f12_early", 10, 0, -1, 1'b0, 14'h0, MEL9, 0, rot18(MEL9, 1'b1), 1'b0, 1'b0);
    check("early.slot", 32'(slot), 32'd0);
    check("early.sl",   32'(sync_lost), 32'd1);
    check("early.dac",  32'(dac), 32'd0);
    run_frame("f13_resync1", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, 0, 1'b0, 1'b1);
    run_frame("f14_resync2", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, 0, 1'b0, 1'b1);
    run_frame("f15_run", -1, 1, -1, 1'b0, 14'h0, MEL9, 0, rot18(MEL9, 1'b1), 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ikaopll_dac_seq.md
IKAOPLL_DAC_SEQ -- requirements
Module: IKAOPLL_dac_seq

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 18, meaning cycles per sample frame (legal range 8..31).
REQ-002 SHALL have port i_EMUCLK  in  1  emulator master clock, the only clock.
REQ-003 SHALL have port i_RST_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_phi1_NCEN_n  in  1  active-low phi1 clock enable; all state advances only on i_EMUCLK rising edges with i_phi1_NCEN_n=0, except reset.
REQ-005 SHALL have port i_CYCLE_00  in  1  frame-start marker from the timing generator.
REQ-006 SHALL have port i_RHYTHM_EN  in  1  requested rhythm mode.
REQ-007 SHALL have port i_MUTE  in  14  mute mask, bits 8:0 melody CH1..CH9, bits 13:9 rhythm BD,HH,SD,TOM,CYM.
REQ-008 SHALL have ports o_MO_CTRL, o_RO_CTRL, o_DAC_EN, o_INHIBIT_FDBK  out  1 each  DAC timing controls.
REQ-009 SHALL have port o_CYCLE_00  out  1  regenerated frame start.
REQ-010 SHALL have port o_SLOT  out  5  current cycle index 0..FRAME_LEN-1.
REQ-011 SHALL have ports o_RHYTHM_EN_EFF  out  1  applied rhythm mode; o_SYNC_LOST  out  1  sticky sync error.

Function
REQ-012 SHALL contain FSM states UNSYNC, RUN, RESYNC.
REQ-013 UNSYNC: counter held at 0, all control outputs 0, o_INHIBIT_FDBK=1; i_CYCLE_00=1 -> RUN with slot 0 next cycle.
REQ-014 RUN: slot increments by 1 per enabled cycle, wraps FRAME_LEN-1 -> 0; o_CYCLE_00=1 exactly when slot=0.
REQ-015 In RUN, i_CYCLE_00=1 at a slot other than FRAME_LEN-1 (i.e. preceding a non-zero next slot) SHALL set o_SYNC_LOST, force slot to 0 next cycle, enter RESYNC.
REQ-016 In RUN, wrap to 0 without i_CYCLE_00 at FRAME_LEN-1 SHALL set o_SYNC_LOST, enter RESYNC, continue counting.
REQ-017 RESYNC: controls as RUN but o_DAC_EN=0; two consecutive frames with correct i_CYCLE_00 -> RUN; o_SYNC_LOST clears only on reset.
REQ-018 i_RHYTHM_EN and i_MUTE SHALL be sampled only on the cycle slot=FRAME_LEN-1 and applied from slot 0; mid-frame changes SHALL have no effect until next boundary.
REQ-019 Melody slot table (9ch mode): CH1..CH9 = 5,8,9,13,16,17,3,0,1; rhythm mode: CH1..CH6 only.
REQ-020 Rhythm slot table: BD,HH,SD,TOM,CYM = 0,1,2,3,4 when o_RHYTHM_EN_EFF=1.
REQ-021 o_MO_CTRL=1 on an active, unmuted melody slot; o_RO_CTRL=1 on an active, unmuted rhythm slot; never both.
REQ-022 o_INHIBIT_FDBK SHALL equal NOT(o_MO_CTRL OR o_RO_CTRL) of the same cycle.
REQ-023 o_DAC_EN SHALL be o_MO_CTRL OR o_RO_CTRL delayed one enabled cycle, gated to 0 outside RUN.
REQ-024 All outputs SHALL be registered; slot-dependent outputs change on the same enable edge as o_SLOT.
REQ-025 Slots >= FRAME_LEN in the tables SHALL never assert.

Reset
REQ-026 On i_RST_n=0 at an i_EMUCLK edge (regardless of enable): state UNSYNC, slot 0, o_MO_CTRL=o_RO_CTRL=o_DAC_EN=o_CYCLE_00=0, o_INHIBIT_FDBK=1, o_RHYTHM_EN_EFF=0, applied mute=0, o_SYNC_LOST=0.
REQ-027 Reset mid-frame SHALL discard pending mode/mute samples; first frame after reset follows REQ-013.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, the melody and rhythm slot tables, and FRAME_LEN default.
REQ-029 One sub-module SHALL be natural: IKAOPLL_dac_seq_slotdec (combinational slot + mode + mask -> MO/RO decode).

Verification
REQ-030 Reset, then i_CYCLE_00 pulses every 18 cycles, i_RHYTHM_EN=0, i_MUTE=0 -> o_MO_CTRL high on slots 0,1,3,5,8,9,13,16,17 only; o_DAC_EN one cycle later; o_SYNC_LOST=0.
REQ-031 Toggle i_RHYTHM_EN 0->1 at slot 7 -> no change that frame; next frame o_RO_CTRL on slots 0..4, o_MO_CTRL on 5,8,9,13,16,17 only.
REQ-032 i_MUTE=14'h2001 (CH1+CYM) in rhythm mode -> slots 5 and 4 silent, o_INHIBIT_FDBK=1 there.
REQ-033 Early i_CYCLE_00 at slot 10 -> o_SYNC_LOST=1, slot 0 next, o_DAC_EN=0 for two frames, then RUN output as REQ-030.
REQ-034 Missing i_CYCLE_00 for one frame -> o_SYNC_LOST=1, counting continues, o_DAC_EN suppressed until two good frames.
REQ-035 Assert i_RST_n=0 at slot 12 with i_phi1_NCEN_n=1 -> all outputs at reset values next edge; no output until next i_CYCLE_00.
